// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// the architectural zero register.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard sources: load-use dependency between EX and ID, and
// an outstanding data-memory access that has not completed this cycle.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_useRt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rd,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       load_use,
    output logic       mem_miss
);

    logic rs_match;
    logic rt_match;

    // Writes to r0 are discarded, so a load into r0 never creates a dependency.
    assign rs_match = (EX_rd == ID_rs);
    assign rt_match = ID_useRt && (EX_rd == ID_rt);
    assign load_use = EX_MemRead && (EX_rd != REG_ZERO) && (rs_match || rt_match);

    assign mem_miss = mem_req && !mem_ready;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: load-use, control transfer
// and multi-cycle data-memory wait with timeout abort.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_useRt,
    input  logic             ID_jump,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd,
    input  logic             EX_branchTaken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_Stall,
    output logic             ID_Stall,
    output logic             ID_Flush,
    output logic             EX_Stall,
    output logic             EX_Flush,
    output logic             M_Stall,
    output logic             MEM_Stall,
    output logic             MEM_Flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              WC_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [WC_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic            mem_err_reg, mem_err_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic load_use;
    logic mem_miss;
    logic freeze;

    hazard_detect u_detect (
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .ID_useRt   (ID_useRt),
        .EX_MemRead (EX_MemRead),
        .EX_rd      (EX_rd),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .load_use   (load_use),
        .mem_miss   (mem_miss)
    );

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = 1'b0;
        freeze        = 1'b0;
        PC_Stall      = 1'b0;
        ID_Stall      = 1'b0;
        ID_Flush      = 1'b0;
        EX_Stall      = 1'b0;
        EX_Flush      = 1'b0;
        M_Stall       = 1'b0;
        MEM_Stall     = 1'b0;
        MEM_Flush     = 1'b0;

        if (!rst) begin
            unique case (state_reg)
                RUN: begin
                    if (mem_miss) begin
                        freeze        = 1'b1;
                        state_next    = MEM_WAIT;
                        wait_cnt_next = WC_W'(1);
                    end else if (EX_branchTaken) begin
                        ID_Flush = 1'b1;
                        EX_Flush = 1'b1;
                    end else if (load_use) begin
                        // A pending jump stays held in ID and flushes once the stall clears.
                        PC_Stall = 1'b1;
                        ID_Stall = 1'b1;
                        EX_Flush = 1'b1;
                    end else if (ID_jump) begin
                        ID_Flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Branch/jump sources are frozen here and re-present after release.
                    if (mem_ready) begin
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else if (wait_cnt_reg == WC_LAST) begin
                        MEM_Flush     = 1'b1;
                        mem_err_next  = 1'b1;
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else begin
                        freeze        = 1'b1;
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end
            endcase
        end

        // Upstream registers hold while MEM/WB takes a bubble.
        if (freeze) begin
            PC_Stall  = 1'b1;
            ID_Stall  = 1'b1;
            EX_Stall  = 1'b1;
            M_Stall   = 1'b1;
            MEM_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            mem_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
            if (PC_Stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign mem_err   = mem_err_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: a cycle-level behavioural model
// plus per-vector hand-computed literals, checked on every falling edge.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 16;

    // Output vector order: {PC_S, ID_S, ID_F, EX_S, EX_F, M_S, MEM_S, MEM_F}
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] FRZ  = 8'b1101_0101;
    localparam logic [7:0] LU   = 8'b1100_1000;
    localparam logic [7:0] BR   = 8'b0010_1000;
    localparam logic [7:0] JMP  = 8'b0010_0000;
    localparam logic [7:0] ABT  = 8'b0000_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    ID_rs, ID_rt, EX_rd;
    logic          ID_useRt, ID_jump, EX_MemRead, EX_branchTaken, mem_req, mem_ready;
    logic          PC_Stall, ID_Stall, ID_Flush, EX_Stall, EX_Flush, M_Stall, MEM_Stall, MEM_Flush;
    logic          mem_err;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .ID_useRt       (ID_useRt),
        .ID_jump        (ID_jump),
        .EX_MemRead     (EX_MemRead),
        .EX_rd          (EX_rd),
        .EX_branchTaken (EX_branchTaken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .PC_Stall       (PC_Stall),
        .ID_Stall       (ID_Stall),
        .ID_Flush       (ID_Flush),
        .EX_Stall       (EX_Stall),
        .EX_Flush       (EX_Flush),
        .M_Stall        (M_Stall),
        .MEM_Stall      (MEM_Stall),
        .MEM_Flush      (MEM_Flush),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt)
    );

    typedef struct {
        logic       r;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       j;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [7:0] lout;
        int         lerr;
        int         lcnt;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;
    bit   active = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    function automatic vec_t v(logic r, int rs, int rt, logic urt, logic j, logic mr, int rd,
                               logic br, logic req, logic rdy, logic [7:0] lo, int le, int lc);
        vec_t x;
        x.r = r; x.rs = 5'(rs); x.rt = 5'(rt); x.urt = urt; x.j = j; x.mr = mr;
        x.rd = 5'(rd); x.br = br; x.req = req; x.rdy = rdy;
        x.lout = lo; x.lerr = le; x.lcnt = lc;
        return x;
    endfunction

    // Checker: model state is "waiting since cycle start", pending error, stall count.
    initial begin
        bit         waiting;
        bit         known;
        bit         err_exp;
        bit         abort;
        int         start;
        int         cyc;
        int         cnt_exp;
        logic [7:0] got;
        logic [7:0] exp_o;
        waiting = 0; known = 0; err_exp = 0; start = 0; cyc = 0; cnt_exp = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (active) begin
                got = {PC_Stall, ID_Stall, ID_Flush, EX_Stall, EX_Flush, M_Stall, MEM_Stall, MEM_Flush};
                abort = 0;
                if (rst) begin
                    exp_o = NONE;
                end else if (waiting) begin
                    if (mem_ready) begin
                        exp_o = NONE;
                    end else if (cyc - start == TO - 1) begin
                        exp_o = ABT;
                        abort = 1;
                    end else begin
                        exp_o = FRZ;
                    end
                end else if (mem_req && !mem_ready) begin
                    exp_o = FRZ;
                end else if (EX_branchTaken) begin
                    exp_o = BR;
                end else if (EX_MemRead && EX_rd != 0 &&
                             (EX_rd == ID_rs || (ID_useRt && EX_rd == ID_rt))) begin
                    exp_o = LU;
                end else if (ID_jump) begin
                    exp_o = JMP;
                end else begin
                    exp_o = NONE;
                end

                total++;
                if (got !== exp_o) begin
                    bad++;
                    $display("FAIL model_out cyc=%0d got=%b want=%b", cyc, got, exp_o);
                end
                if (known) begin
                    total++;
                    if (mem_err !== err_exp) begin
                        bad++;
                        $display("FAIL model_err cyc=%0d got=%b want=%b", cyc, mem_err, err_exp);
                    end
                    total++;
                    if (int'(stall_cnt) != cnt_exp) begin
                        bad++;
                        $display("FAIL model_cnt cyc=%0d got=%0d want=%0d", cyc, stall_cnt, cnt_exp);
                    end
                end

                total++;
                if (got !== cur.lout) begin
                    bad++;
                    $display("FAIL lit_out cyc=%0d got=%b want=%b", cyc, got, cur.lout);
                end
                if (cur.lerr >= 0) begin
                    total++;
                    if (mem_err !== cur.lerr[0]) begin
                        bad++;
                        $display("FAIL lit_err cyc=%0d got=%b want=%0d", cyc, mem_err, cur.lerr);
                    end
                end
                if (cur.lcnt >= 0) begin
                    total++;
                    if (int'(stall_cnt) != cur.lcnt) begin
                        bad++;
                        $display("FAIL lit_cnt cyc=%0d got=%0d want=%0d", cyc, stall_cnt, cur.lcnt);
                    end
                end

                if (rst) begin
                    waiting = 0; err_exp = 0; cnt_exp = 0; known = 1;
                end else begin
                    err_exp = abort;
                    if (exp_o[7] && cnt_exp < (1 << CW) - 1) cnt_exp++;
                    if (waiting) begin
                        if (mem_ready || abort) waiting = 0;
                    end else if (mem_req && !mem_ready) begin
                        waiting = 1;
                        start   = cyc;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; ID_rs = '0; ID_rt = '0; ID_useRt = 1'b0; ID_jump = 1'b0;
        EX_MemRead = 1'b0; EX_rd = '0; EX_branchTaken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        //                r rs rt u j mr rd br rq rdy  out  err cnt
        vecs.push_back(v(1, 0, 0, 0,0, 0, 0, 0, 0, 0, NONE, -1, -1));
        vecs.push_back(v(1, 0, 0, 0,0, 0, 0, 0, 0, 0, NONE,  0,  0));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 0, 0, NONE,  0,  0));
        // load-use on rs, r0 exemption, rt use/no-use
        vecs.push_back(v(0, 8, 0, 0,0, 1, 8, 0, 0, 0, LU,    0,  0));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 0, 0, NONE,  0,  1));
        vecs.push_back(v(0, 8, 0, 0,0, 1, 0, 0, 0, 0, NONE,  0,  1));
        vecs.push_back(v(0, 3, 9, 1,0, 1, 9, 0, 0, 0, LU,    0,  1));
        vecs.push_back(v(0, 3, 9, 0,0, 1, 9, 0, 0, 0, NONE,  0,  2));
        // branch vs jump, branch vs load-use, load-use vs jump
        vecs.push_back(v(0, 0, 0, 0,1, 0, 0, 1, 0, 0, BR,    0,  2));
        vecs.push_back(v(0, 0, 0, 0,1, 0, 0, 0, 0, 0, JMP,   0,  2));
        vecs.push_back(v(0, 8, 0, 0,0, 1, 8, 1, 0, 0, BR,    0,  2));
        vecs.push_back(v(0, 8, 0, 0,1, 1, 8, 0, 0, 0, LU,    0,  2));
        // 3-cycle miss then release
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0,  3));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0,  4));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0,  5));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 1, NONE,  0,  6));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 0, 0, NONE,  0,  6));
        // timeout abort and one-cycle mem_err
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0,  6));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0,  7));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0,  8));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, ABT,   0,  9));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 0, 0, NONE,  1,  9));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 0, 0, NONE,  0,  9));
        // branch suppressed while waiting, flushes after release
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 1, 1, 0, FRZ,   0,  9));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 1, 1, 0, FRZ,   0, 10));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 1, 1, 1, NONE,  0, 11));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 1, 0, 0, BR,    0, 11));
        // reset mid-wait, then a fresh miss
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0, 11));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0, 12));
        vecs.push_back(v(1, 0, 0, 0,0, 0, 0, 0, 1, 0, NONE,  0, 13));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 0, 0, NONE,  0,  0));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0,  0));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0,  1));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 0, FRZ,   0,  2));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 1, 1, NONE,  0,  3));
        vecs.push_back(v(0, 0, 0, 0,0, 0, 0, 0, 0, 0, NONE,  0,  3));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst            = vecs[i].r;
            ID_rs          = vecs[i].rs;
            ID_rt          = vecs[i].rt;
            ID_useRt       = vecs[i].urt;
            ID_jump        = vecs[i].j;
            EX_MemRead     = vecs[i].mr;
            EX_rd          = vecs[i].rd;
            EX_branchTaken = vecs[i].br;
            mem_req        = vecs[i].req;
            mem_ready      = vecs[i].rdy;
            cur            = vecs[i];
            active         = 1'b1;
        end
        @(posedge clk);
        #1;
        active = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
